// File: rtl/issue_pkg.sv
// issue_pkg: definitions shared by the issue-queue select logic.
//   - queue geometry: CIQ_DEPTH, AGE_WIDTH, PRF_WIDTH, OPCODE_WIDTH
//   - opcode-class constants each issue port can be bound to
//   - state encoding for the multi-cycle occupancy FSM
package issue_pkg;

  localparam int CIQ_DEPTH    = 16;
  localparam int AGE_WIDTH    = 5;
  localparam int PRF_WIDTH    = 6;
  localparam int OPCODE_WIDTH = 7;

  localparam logic [OPCODE_WIDTH-1:0] ALU  = 7'b0110011;
  localparam logic [OPCODE_WIDTH-1:0] MUL  = 7'b0111011;
  localparam logic [OPCODE_WIDTH-1:0] LOAD = 7'b0000011;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } fu_state_e;

endpackage

// File: rtl/issue_select_oldest.sv
// oldest_select: combinational oldest-candidate picker.
//   cand   in  N      candidate entries
//   age    in  N*AW   flattened modulo age tags, entry i at [i*AW +: AW]
//   found  out 1      at least one candidate present
//   idx    out IW     index of the oldest candidate
//   onehot out N      one-hot of idx, zero when nothing found
// N must be a power of two. The tree is stored as a heap: node k has
// children 2k+1 / 2k+2 and leaves sit at N-1..2N-2 in entry order, so the
// left child always covers lower indices and wins on equal ages.
module oldest_select #(
  parameter int N  = 16,
  parameter int AW = 5,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]    cand,
  input  logic [N*AW-1:0] age,
  output logic            found,
  output logic [IW-1:0]   idx,
  output logic [N-1:0]    onehot
);
  import issue_pkg::*;

  localparam logic [AW-1:0] HALF = {1'b1, {(AW-1){1'b0}}};

  // a is older than b when b is ahead of a by less than half the age space
  function automatic logic is_older(input logic [AW-1:0] a, input logic [AW-1:0] b);
    logic [AW-1:0] d;
    d = b - a;
    return (d != '0) && (d < HALF);
  endfunction

  logic [2*N-2:0] nv;
  logic [IW-1:0]  ni [2*N-1];
  logic [AW-1:0]  na [2*N-1];

  for (genvar k = 0; k < N; k++) begin : g_leaf
    assign nv[N-1+k] = cand[k];
    assign ni[N-1+k] = IW'(k);
    assign na[N-1+k] = age[k*AW +: AW];
  end

  for (genvar k = 0; k < N-1; k++) begin : g_node
    logic take_r;
    assign take_r = nv[2*k+2] && (!nv[2*k+1] || is_older(na[2*k+2], na[2*k+1]));
    assign nv[k]  = nv[2*k+1] | nv[2*k+2];
    assign ni[k]  = take_r ? ni[2*k+2] : ni[2*k+1];
    assign na[k]  = take_r ? na[2*k+2] : na[2*k+1];
  end

  assign found  = nv[0];
  assign idx    = ni[0];
  assign onehot = found ? ({{(N-1){1'b0}}, 1'b1} << idx) : '0;

endmodule

// File: rtl/issue_select.sv
// issue_select: per-port select scheduler for the centralized issue queue.
//   clk, rst       clock, asynchronous active-high reset
//   req            per-entry ready request
//   op, age        flattened per-entry opcode and age tag
//   fu_ready       downstream unit can accept
//   flush          synchronous pipeline flush
//   grant_valid    registered grant strobe
//   grant_addr     registered granted index (holds when no grant)
//   grant_onehot   registered one-hot of the grant, zero when not valid
//   fu_busy        multi-cycle unit occupied
//   multi_finish   pulse in the last occupied cycle
//
// state   | meaning
// ST_IDLE | unit free, a grant may issue
// ST_BUSY | multi-cycle unit occupied, cnt counts down to the finish cycle
module issue_select #(
  parameter int                      CIQ_DEPTH    = 16,
  parameter int                      AGE_WIDTH    = 5,
  parameter int                      OPCODE_WIDTH = 7,
  parameter logic [OPCODE_WIDTH-1:0] OP_CLASS     = 7'b0110011,
  parameter int                      MULTI_CYCLE  = 0,
  parameter int                      FU_LATENCY   = 3
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [CIQ_DEPTH-1:0]              req,
  input  logic [CIQ_DEPTH*OPCODE_WIDTH-1:0] op,
  input  logic [CIQ_DEPTH*AGE_WIDTH-1:0]    age,
  input  logic                              fu_ready,
  input  logic                              flush,
  output logic                              grant_valid,
  output logic [$clog2(CIQ_DEPTH)-1:0]      grant_addr,
  output logic [CIQ_DEPTH-1:0]              grant_onehot,
  output logic                              fu_busy,
  output logic                              multi_finish
);
  import issue_pkg::*;

  localparam int IW    = $clog2(CIQ_DEPTH);
  localparam int CNT_W = (FU_LATENCY > 1) ? $clog2(FU_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FU_LATENCY - 1);

  fu_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 grant_valid_q, grant_valid_d;
  logic [IW-1:0]        grant_addr_q, grant_addr_d;
  logic [CIQ_DEPTH-1:0] grant_onehot_q, grant_onehot_d;

  logic [CIQ_DEPTH-1:0] op_match;
  logic [CIQ_DEPTH-1:0] cand;
  logic                 sel_found;
  logic [IW-1:0]        sel_idx;
  logic [CIQ_DEPTH-1:0] sel_onehot;
  logic                 sel_en;
  logic                 issue;

  // The entry granted last cycle still shows req until the queue's ISSUED
  // bit lands, so it is masked out for one cycle.
  always_comb begin
    op_match = '0;
    for (int i = 0; i < CIQ_DEPTH; i++) begin
      op_match[i] = (op[i*OPCODE_WIDTH +: OPCODE_WIDTH] == OP_CLASS);
    end
    cand = req & op_match & ~(grant_valid_q ? grant_onehot_q : '0);
  end

  oldest_select #(
    .N  (CIQ_DEPTH),
    .AW (AGE_WIDTH),
    .IW (IW)
  ) u_oldest (
    .cand   (cand),
    .age    (age),
    .found  (sel_found),
    .idx    (sel_idx),
    .onehot (sel_onehot)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM outputs
  always_comb begin
    fu_busy      = (state_q == ST_BUSY);
    multi_finish = (state_q == ST_BUSY) && (cnt_q == '0) && !flush;
  end

  // FSM next state; a grant in the finish cycle reloads BUSY back-to-back
  always_comb begin
    sel_en  = fu_ready && !flush && ((state_q == ST_IDLE) || multi_finish);
    issue   = sel_en && sel_found;
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if ((MULTI_CYCLE != 0) && issue) begin
      state_d = ST_BUSY;
      cnt_d   = CNT_LOAD;
    end else if (state_q == ST_BUSY) begin
      if (cnt_q == '0) begin
        state_d = ST_IDLE;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  always_comb begin
    grant_valid_d  = issue;
    grant_onehot_d = issue ? sel_onehot : '0;
    if (flush) begin
      grant_addr_d = '0;
    end else if (issue) begin
      grant_addr_d = sel_idx;
    end else begin
      grant_addr_d = grant_addr_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_valid_q  <= 1'b0;
      grant_addr_q   <= '0;
      grant_onehot_q <= '0;
    end else begin
      grant_valid_q  <= grant_valid_d;
      grant_addr_q   <= grant_addr_d;
      grant_onehot_q <= grant_onehot_d;
    end
  end

  assign grant_valid  = grant_valid_q;
  assign grant_addr   = grant_addr_q;
  assign grant_onehot = grant_onehot_q;

endmodule
